// File: rtl/memory_subsystem.sv
`default_nettype none
// ============================================================================
// Module   : memory_subsystem
// Purpose  : MAR/MDR registers, 512x32 RAM and access FSM with busy/done
//            status. Define MEM_WAIT_EN to honour WAIT_CYCLES wait states.
// Revision : 1.0 - initial release
// ============================================================================
module memory_subsystem #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic                  MARin,
    input  logic                  MDRin,
    input  logic                  read,
    input  logic                  write,
    input  logic                  RAMenable,
    output logic [DATA_WIDTH-1:0] mdr_out,
    output logic [ADDR_WIDTH-1:0] mar_out,
    output logic                  mem_busy,
    output logic                  mem_done
);

    localparam int c_depth = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_mar;
    logic [DATA_WIDTH-1:0] r_mdr;
    logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];
    logic                  w_rd_req;
    logic                  w_wr_req;
    logic                  w_req;
    logic                  w_acc_rd;
    logic                  w_acc_wr;

    assign w_rd_req = RAMenable & read & ~write;
    assign w_wr_req = RAMenable & write & ~read;
    assign w_req    = w_rd_req | w_wr_req;
    assign mdr_out  = r_mdr;
    assign mar_out  = r_mar;

`ifdef MEM_WAIT_EN
    localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES - 1);

    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic       r_wait_wr;
    logic       w_wait_wr_next;

    // r_wait_wr remembers the request type so a read/write swap aborts the wait
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= 4'd0;
            r_wait_wr <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_wait_wr <= w_wait_wr_next;
        end
    end
`else
    localparam int c_unused_wait = WAIT_CYCLES;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_acc_rd = 1'b0;
        w_acc_wr = 1'b0;
        mem_busy = 1'b0;
        mem_done = 1'b0;
`ifdef MEM_WAIT_EN
        w_cnt_next     = r_cnt;
        w_wait_wr_next = r_wait_wr;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
`ifdef MEM_WAIT_EN
                    if (WAIT_CYCLES == 0) begin
                        w_acc_rd = w_rd_req;
                        w_acc_wr = w_wr_req;
                        w_next   = S_DONE;
                    end else begin
                        w_cnt_next     = c_wait_load;
                        w_wait_wr_next = w_wr_req;
                        w_next         = S_WAIT;
                    end
`else
                    w_acc_rd = w_rd_req;
                    w_acc_wr = w_wr_req;
                    w_next   = S_DONE;
`endif
                end
            end
            S_WAIT: begin
`ifdef MEM_WAIT_EN
                mem_busy = 1'b1;
                if (!w_req || (w_wr_req != r_wait_wr)) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_acc_rd = w_rd_req;
                    w_acc_wr = w_wr_req;
                    w_next   = S_DONE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
`else
                w_next = S_IDLE;
`endif
            end
            S_DONE: begin
                mem_done = 1'b1;
                w_next   = RAMenable ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (!RAMenable) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // During a read MDR only moves on the access edge; otherwise it follows bus_in
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mar <= '0;
            r_mdr <= '0;
        end else begin
            if (MARin) begin
                r_mar <= bus_in[ADDR_WIDTH-1:0];
            end
            if (MDRin) begin
                if (!w_rd_req) begin
                    r_mdr <= bus_in;
                end else if (w_acc_rd) begin
                    r_mdr <= r_mem[r_mar];
                end
            end
        end
    end

    // Gated by reset so a request present while reset is low cannot write
    always_ff @(posedge clk) begin
        if (reset && w_acc_wr) begin
            r_mem[r_mar] <= r_mdr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_subsystem.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_subsystem
// Purpose  : Randomised self-checking bench for memory_subsystem against a
//            word-array reference model of the RAM, MAR and MDR.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_subsystem;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int WC = 2;
    localparam int EFF_WAIT =
`ifdef MEM_WAIT_EN
        WC;
`else
        0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] bus_in;
    logic          MARin, MDRin, read, write, RAMenable;
    logic [DW-1:0] mdr_out;
    logic [AW-1:0] mar_out;
    logic          mem_busy, mem_done;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model_mem [0:511];
    bit            known     [0:511];

    always #5 clk = ~clk;

    memory_subsystem #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus_in   (bus_in),
        .MARin    (MARin),
        .MDRin    (MDRin),
        .read     (read),
        .write    (write),
        .RAMenable(RAMenable),
        .mdr_out  (mdr_out),
        .mar_out  (mar_out),
        .mem_busy (mem_busy),
        .mem_done (mem_done)
    );

    task automatic set_mar(input logic [DW-1:0] v);
        bus_in = v; MARin = 1'b1;
        @(posedge clk); #1;
        MARin = 1'b0;
    endtask

    task automatic set_mdr(input logic [DW-1:0] v);
        bus_in = v; MDRin = 1'b1;
        @(posedge clk); #1;
        MDRin = 1'b0;
    endtask

    // Holds a request for 'hold' edges, then drops it for one settling edge
    task automatic run_access(input bit is_wr, input bit mdrin, input int hold,
                              output int busy_n, output int done_n,
                              output int done_at, output logic [DW-1:0] mdr_seen);
        read = !is_wr; write = is_wr; MDRin = mdrin; RAMenable = 1'b1;
        bus_in = $urandom;
        busy_n = 0; done_n = 0; done_at = -1; mdr_seen = mdr_out;
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk); #1;
            if (mem_busy) busy_n++;
            if (mem_done) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            mdr_seen = mdr_out;
        end
        RAMenable = 1'b0; read = 1'b0; write = 1'b0; MDRin = 1'b0;
        @(posedge clk); #1;
        if (mem_done) done_n++;
        if (mem_busy) busy_n++;
    endtask

    task automatic model_write(input int a, input logic [DW-1:0] d);
        model_mem[a] = d; known[a] = 1'b1;
    endtask

    task automatic test_reset();
        int b, d, at;
        logic [DW-1:0] seen, va, vb;
        if (mdr_out !== '0) begin errors++; $display("FAIL reset_mdr: got %h want 0", mdr_out); end
        checks++;
        if (mar_out !== '0) begin errors++; $display("FAIL reset_mar: got %h want 0", mar_out); end
        checks++;
        if (mem_busy !== 1'b0 || mem_done !== 1'b0) begin
            errors++; $display("FAIL reset_status: busy=%b done=%b want 0 0", mem_busy, mem_done);
        end
        checks++;
        #3 reset = 1'b1;
        @(posedge clk); #1;
        va = $urandom | 32'h1;
        vb = va ^ 32'h5A5A_0F0F;
        set_mar(32'h20); set_mdr(va);
        run_access(1'b1, 1'b0, EFF_WAIT + 4, b, d, at, seen);
        model_write(32'h20, va);
        set_mdr(vb);
        write = 1'b1; RAMenable = 1'b1;
        @(posedge clk); #1;
        if (mem_busy !== (EFF_WAIT > 0)) begin
            errors++; $display("FAIL busy_before_reset: got %b want %b", mem_busy, EFF_WAIT > 0);
        end
        checks++;
        #2 reset = 1'b0;
        #1;
        if (mdr_out !== '0 || mar_out !== '0) begin
            errors++; $display("FAIL midsim_reset_regs: mdr=%h mar=%h want 0 0", mdr_out, mar_out);
        end
        checks++;
        if (mem_busy !== 1'b0 || mem_done !== 1'b0) begin
            errors++; $display("FAIL midsim_reset_status: busy=%b done=%b want 0 0", mem_busy, mem_done);
        end
        checks++;
        write = 1'b0; RAMenable = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        if (EFF_WAIT == 0) model_write(32'h20, vb);
        set_mar(32'h20);
        run_access(1'b0, 1'b1, EFF_WAIT + 4, b, d, at, seen);
        if (seen !== model_mem[32'h20]) begin
            errors++; $display("FAIL reset_abort_ram: got %h want %h", seen, model_mem[32'h20]);
        end
        checks++;
    endtask

    task automatic test_store();
        int b, d, at;
        logic [DW-1:0] seen;
        set_mar(32'h0000_0041);
        if (mar_out !== 9'h041) begin errors++; $display("FAIL store_mar: got %h want 041", mar_out); end
        checks++;
        set_mdr(32'hDEAD_BEEF);
        if (mdr_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_mdr: got %h want deadbeef", mdr_out); end
        checks++;
        run_access(1'b1, 1'b0, EFF_WAIT + 4, b, d, at, seen);
        model_write(32'h41, 32'hDEAD_BEEF);
        if (d !== 1 || at !== EFF_WAIT + 1) begin
            errors++; $display("FAIL store_done: pulses=%0d at=%0d want 1 at %0d", d, at, EFF_WAIT + 1);
        end
        checks++;
        if (b !== EFF_WAIT) begin errors++; $display("FAIL store_busy: got %0d want %0d", b, EFF_WAIT); end
        checks++;
    endtask

    task automatic test_load();
        int b, d, at;
        logic [DW-1:0] seen;
        set_mdr($urandom & 32'h7FFF_FFFF);
        set_mar(32'h41);
        run_access(1'b0, 1'b1, EFF_WAIT + 4, b, d, at, seen);
        if (seen !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data: got %h want deadbeef", seen); end
        checks++;
        if (d !== 1 || at !== EFF_WAIT + 1) begin
            errors++; $display("FAIL load_done: pulses=%0d at=%0d want 1 at %0d", d, at, EFF_WAIT + 1);
        end
        checks++;
        if (b !== EFF_WAIT) begin errors++; $display("FAIL load_busy: got %0d want %0d", b, EFF_WAIT); end
        checks++;
    endtask

    task automatic test_abort();
        int b, d, at;
        logic [DW-1:0] seen, vy;
        set_mar(32'h10); set_mdr(32'h1234_5678);
        run_access(1'b1, 1'b0, EFF_WAIT + 4, b, d, at, seen);
        model_write(32'h10, 32'h1234_5678);
        vy = $urandom;
        set_mdr(vy);
        run_access(1'b1, 1'b0, 1, b, d, at, seen);
        if (EFF_WAIT == 0) model_write(32'h10, vy);
        if (d !== ((EFF_WAIT == 0) ? 1 : 0)) begin
            errors++; $display("FAIL abort_done: got %0d want %0d", d, (EFF_WAIT == 0) ? 1 : 0);
        end
        checks++;
        if (mem_busy !== 1'b0) begin errors++; $display("FAIL abort_idle: busy=%b want 0", mem_busy); end
        checks++;
        run_access(1'b0, 1'b1, EFF_WAIT + 4, b, d, at, seen);
        if (seen !== model_mem[32'h10]) begin
            errors++; $display("FAIL abort_ram: got %h want %h", seen, model_mem[32'h10]);
        end
        checks++;
    endtask

    task automatic test_illegal();
        int b, d, at;
        logic [DW-1:0] seen, v;
        v = $urandom;
        set_mar(32'h41); set_mdr(v);
        read = 1'b1; write = 1'b1; RAMenable = 1'b1; bus_in = ~v;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (mem_busy !== 1'b0 || mem_done !== 1'b0 || mdr_out !== v) begin
                errors++;
                $display("FAIL illegal_cycle%0d: busy=%b done=%b mdr=%h want 0 0 %h",
                         k, mem_busy, mem_done, mdr_out, v);
            end
            checks++;
        end
        read = 1'b0; write = 1'b0; RAMenable = 1'b0;
        run_access(1'b0, 1'b1, EFF_WAIT + 4, b, d, at, seen);
        if (seen !== model_mem[32'h41]) begin
            errors++; $display("FAIL illegal_ram: got %h want %h", seen, model_mem[32'h41]);
        end
        checks++;
    endtask

    task automatic test_wrap();
        int b, d, at;
        logic [DW-1:0] seen;
        set_mar(32'h0000_0241);
        if (mar_out !== 9'h041) begin errors++; $display("FAIL wrap_mar: got %h want 041", mar_out); end
        checks++;
        set_mar({$urandom_range(1, 255), 24'h0} | 32'h41);
        run_access(1'b0, 1'b1, EFF_WAIT + 4, b, d, at, seen);
        if (seen !== model_mem[32'h41]) begin
            errors++; $display("FAIL wrap_read: got %h want %h", seen, model_mem[32'h41]);
        end
        checks++;
    endtask

    task automatic test_random();
        int b, d, at, a;
        logic [DW-1:0] seen, v;
        for (int i = 0; i < 24; i++) begin
            a = $urandom_range(0, 511);
            set_mar({$urandom_range(0, 8388607), a[8:0]});
            if (!known[a] || ($urandom_range(0, 1) == 1)) begin
                v = $urandom;
                set_mdr(v);
                run_access(1'b1, 1'b0, EFF_WAIT + 3, b, d, at, seen);
                model_write(a, v);
            end else begin
                run_access(1'b0, 1'b1, EFF_WAIT + 3, b, d, at, seen);
                if (seen !== model_mem[a]) begin
                    errors++; $display("FAIL rand_read[%0d] addr %h: got %h want %h", i, a, seen, model_mem[a]);
                end
                checks++;
            end
            if (d !== 1) begin errors++; $display("FAIL rand_done[%0d]: got %0d want 1", i, d); end
            checks++;
        end
    endtask

    initial begin
        reset = 1'b0; bus_in = '0; MARin = 1'b0; MDRin = 1'b0;
        read = 1'b0; write = 1'b0; RAMenable = 1'b0;
        for (int i = 0; i < 512; i++) known[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_store();
        test_load();
        test_abort();
        test_illegal();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_subsystem.md
Name: memory_subsystem

Overview:
- Memory stage directly downstream of the CPU control unit. It consumes the control unit's MARin, MDRin, read, write and RAMenable strobes and sources MDR contents back to the bus.
- Contains the MAR and MDR registers, a 512x32 word RAM, and a small access FSM with an optional wait-state counter.
- Produces busy/done status so the control sequencing can stall on slow memory.
- The external bus mux gates mdr_out onto the bus using the control unit's MDRout strobe; that mux is outside this block.

Parameters:
- DATA_WIDTH, 32, word width of bus, MDR and RAM.
- ADDR_WIDTH, 9, MAR width; RAM depth = 2**ADDR_WIDTH words (512).
- WAIT_CYCLES, 2, extra access cycles per read/write; honoured only when MEM_WAIT_EN is defined; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; reset==0 clears all state immediately.
- bus_in  input  DATA_WIDTH  internal CPU bus value.
- MARin  input  1  load MAR from bus_in[ADDR_WIDTH-1:0].
- MDRin  input  1  load MDR (source selected per Behaviour).
- read  input  1  read request qualifier.
- write  input  1  write request qualifier.
- RAMenable  input  1  memory request enable.
- mdr_out  output  DATA_WIDTH  current MDR register contents.
- mar_out  output  ADDR_WIDTH  current MAR contents (debug/trace).
- mem_busy  output  1  high while an access is pending in WAIT.
- mem_done  output  1  one-cycle pulse on the cycle after an access completes.

Behaviour:
- Reset values: MAR=0, MDR=0, mdr_out=0, mar_out=0, mem_busy=0, mem_done=0, FSM=IDLE, wait counter=0. RAM contents are not cleared.
- Request definition:
  - rd_req = RAMenable & read & ~write.
  - wr_req = RAMenable & write & ~read.
  - RAMenable with read and write both high (or both low) is not a request and is ignored.
- MAR: on posedge with MARin=1, MAR <= bus_in[ADDR_WIDTH-1:0]. Upper bus bits are discarded, so the address wraps modulo 512.
- MDR source:
  - With MDRin=1 and no rd_req, MDR <= bus_in.
  - With MDRin=1 and rd_req, MDR loads RAM[MAR] only on the access edge.
  - On non-access edges during a read, MDR holds its value.
- FSM states:
  - IDLE:
    - On rd_req/wr_req with effective wait count 0: perform the access on this edge and go to DONE.
    - Otherwise, with a request: load counter = WAIT_CYCLES-1 and go to WAIT.
  - WAIT:
    - mem_busy=1.
    - If the request drops (RAMenable=0, or request type changes), go to IDLE with no access performed.
    - If counter==0: perform the access and go to DONE.
    - Otherwise decrement the counter.
  - DONE:
    - mem_done=1 for this cycle only.
    - Go to IDLE when RAMenable=0. Otherwise wait in the no-pulse hold substate DONE_HOLD until RAMenable=0, so a held request never re-triggers.
- Access edge actions:
  - Read: MDR <= RAM[MAR] if MDRin=1.
  - Write: RAM[MAR] <= MDR. The write uses the MDR value before any same-edge MDRin load.
- Latency:
  - Access completes (WAIT_CYCLES+1) rising edges after the request is first sampled.
  - With an effective wait count of 0, it completes on the first sampling edge.
- MAR load on the same edge as an access: the access uses the old MAR value; the new value is visible on the next cycle.
- Reset asserted mid-WAIT: the access is aborted, RAM is unmodified, and the FSM returns to IDLE.

Optional Feature:
- Macro MEM_WAIT_EN.
- Defined: WAIT_CYCLES is honoured and mem_busy can assert.
- Undefined: effective wait count is 0 regardless of WAIT_CYCLES. mem_busy is tied 0, the WAIT state and counter are not built, and every access completes on its first sampling edge.

Test Plan:
- Reset: drive reset=0 mid-simulation -> mdr_out=0, mar_out=0, mem_busy=0, mem_done=0 immediately, with no clock edge required.
- Store without MEM_WAIT_EN:
  - Stimulus: bus_in=0x0000_0041 with MARin; then bus_in=0xDEAD_BEEF with MDRin; then write+RAMenable for 1 cycle.
  - Expect: RAM[0x041]=0xDEAD_BEEF, mem_done pulses once.
- Load with MEM_WAIT_EN, WAIT_CYCLES=2:
  - Stimulus: MAR=0x041, then read+MDRin+RAMenable held.
  - Expect: mem_busy=1 for 2 cycles, MDR=0xDEAD_BEEF on the 3rd edge, mem_done pulses 1 cycle, no second access while the request stays held.
- Abort: with MEM_WAIT_EN, start a write to 0x010 then drop RAMenable during WAIT -> RAM[0x010] unchanged, FSM returns to IDLE, mem_done never asserts.
- Illegal request: read=write=RAMenable=1 for 3 cycles -> no RAM change, MDR unchanged, mem_busy=0, mem_done=0.
- Address wrap: MARin with bus_in=0x0000_0241 -> mar_out=0x041; a subsequent read returns RAM[0x041].
